karatsuba_mul: RTL and testbench
================================

Name: karatsuba_mul

Overview:
- Parametrised, pipelined integer multiplier: WIDTH x WIDTH -> 2*WIDTH product, using 3 sub-multiplies (Karatsuba) instead of 4.
- Signed or unsigned mode selected per operation; opaque tag travels with each operation.
- Elastic 4-stage pipeline: each stage has its own valid flag and a bubble-collapsing enable chain.
- Serves as the multiply primitive behind the same new_data/ack_data, release_data/valid_output handshake used by the existing arithmetic blocks.

Parameters:
- WIDTH, 32, operand width; must be even and >= 4 (elaboration error otherwise).
- TAG_W, 4, width of the pass-through tag; must be >= 1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- new_data  in  1  input operation offered.
- ack_data  out  1  input accepted this cycle, asserted when new_data=1 and stage 1 can load.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned.
- tag_in  in  TAG_W  opaque tag.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- release_data  in  1  consumer takes the result.
- valid_output  out  1  result/tag_out valid.
- tag_out  out  TAG_W  tag of the current result.
- result  out  2*WIDTH  product, two's complement when signed_mode was 1.

Behaviour:
- Reset (rst_n=0, async): all stage valids=0, all data registers=0; ack_data=0, valid_output=0, result=0, tag_out=0.
- Stage enables: en5=release_data; en_k = !v_k | en_(k+1), k=4..1. ack_data = new_data & en1.
- Combinational release_data -> ack_data path is intended: a full pipeline accepts one operation in the same cycle the head result is released.
- Stage 1 (en1 & new_data): latch |a| and |b|, sign=(a_msb^b_msb)&signed_mode, tag. In unsigned mode operands pass unchanged. |-2^(WIDTH-1)| = 2^(WIDTH-1), interpreted as WIDTH-bit unsigned.
- Stage 2: split each operand as H = upper WIDTH/2 bits, L = lower WIDTH/2 bits. Compute:
  - z2 = H1*H2 (WIDTH bits)
  - z0 = L1*L2 (WIDTH bits)
  - zs = (H1+L1)*(H2+L2) (WIDTH+2 bits)
- Stage 3: latch {z2,z0} (2*WIDTH bits) and mid = zs-z2-z0, held in WIDTH+1 bits (value is always non-negative).
- Stage 4: p = {z2,z0} + (mid << WIDTH/2), modulo 2^(2*WIDTH); result = sign ? -p : p.
- Each stage's valid loads from the previous stage's valid when its enable is high; otherwise it holds.
- Latency: exactly 4 cycles from the ack_data cycle to valid_output when there is no backpressure. Throughput: 1 operation per cycle.
- Backpressure: valid_output, result and tag_out are held stable while release_data=0. Upstream bubbles collapse. ack_data drops only when all 4 stages are valid and release_data=0.
- release_data while valid_output=0: ignored.
- Ordering: results leave strictly in acceptance order.
- rst_n asserted mid-operation: in-flight operations are discarded, no partial output; first acceptance is possible on the first cycle after release.

Optional Feature:
- Macro KARATSUBA_MUL_ACC_EN.
- Defined:
  - Adds input port accumulate (1 bit), sampled with the operands and carried with the operation.
  - Adds internal acc register (2*WIDTH bits, reset 0).
  - On every stage-4 load: value = p_signed + (accumulate ? acc : 0), modulo 2^(2*WIDTH). The value goes to result and is also written to acc.
  - accumulate=0 therefore restarts the chain. acc tracks operations in pipeline order, so back-to-back dependent operations need no stall.
- Undefined: no accumulate port, no acc register; result = product only.

Decomposition:
- Package karatsuba_mul_pkg:
  - localparams HALF_W=WIDTH/2, MID_W=WIDTH+1, SUM_W=WIDTH+2, RES_W=2*WIDTH, PIPE_STAGES=4.
  - typedef of the per-stage sideband struct {sign, tag, accumulate}.
- Sub-module karatsuba_mul_tracker(STAGES): owns the valid bits and the enable chain and produces ack_data/valid_output. The datapath stays in the top module.

Test Plan (WIDTH=8, TAG_W=4):
- Unsigned 0xFF*0xFF, tag 3 -> result 0xFE01, tag_out 3, valid_output exactly 4 cycles after ack_data, with release_data held at 1.
- Signed -128*-128 -> 0x4000; signed -3*5 -> 0xFFF1; unsigned 0x80*0x02 -> 0x0100. Issue back-to-back; results return in order on consecutive cycles.
- release_data=0, offer 6 ops -> 4 acked, then ack_data=0. result is stable across 10 cycles. Raise release_data -> one op per cycle, tags in order; 5th op acked the same cycle the 1st result releases.
- Insert bubbles (new_data toggling) with release_data=0 -> bubbles collapse, 4 ops held, none lost or duplicated.
- Drop rst_n for 1 cycle with 3 ops in flight -> valid_output=0 and result=0 immediately; no stale result appears afterwards.
- KARATSUBA_MUL_ACC_EN: signed 2*3 (acc=0), then 4*5 (acc=1), then -1*7 (acc=1) -> results 6, 26, 19; then 1*1 (acc=0) -> 1.

Source files
------------

// File: rtl/karatsuba_mul_pkg.sv
// Shared types and width helpers for the Karatsuba multiplier slice.
// Build option: KARATSUBA_MUL_ACC_EN adds a running accumulator to stage 4.
package karatsuba_mul_pkg;

   localparam int unsigned PIPE_STAGES = 4;
   // Widest tag the sideband record can carry; narrower tags are zero-extended.
   localparam int unsigned TAG_MAX_W   = 16;

   // Per-stage sideband that travels alongside the datapath.
   typedef struct packed {
      logic                 sign;
      logic [TAG_MAX_W-1:0] tag;
      logic                 accumulate;
   } side_t;

   // Derived datapath widths for an operand width w.
   function automatic int unsigned half_w(input int unsigned w);
      return w / 2;
   endfunction

   function automatic int unsigned mid_w(input int unsigned w);
      return w + 1;
   endfunction

   function automatic int unsigned sum_w(input int unsigned w);
      return w + 2;
   endfunction

   function automatic int unsigned res_w(input int unsigned w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/karatsuba_mul_if.sv
// Operation/result handshake bundle for the Karatsuba multiplier.
// Build option: KARATSUBA_MUL_ACC_EN adds the accumulate request bit.
interface karatsuba_mul_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
);
   logic               new_data;
   logic               ack_data;
   logic               signed_mode;
   logic [TAG_W-1:0]   tag_in;
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic               release_data;
   logic               valid_output;
   logic [TAG_W-1:0]   tag_out;
   logic [2*WIDTH-1:0] result;
`ifdef KARATSUBA_MUL_ACC_EN
   logic               accumulate;

   modport master (
      output new_data, signed_mode, tag_in, a_in, b_in, release_data, accumulate,
      input  ack_data, valid_output, tag_out, result
   );

   modport slave (
      input  new_data, signed_mode, tag_in, a_in, b_in, release_data, accumulate,
      output ack_data, valid_output, tag_out, result
   );
`else
   modport master (
      output new_data, signed_mode, tag_in, a_in, b_in, release_data,
      input  ack_data, valid_output, tag_out, result
   );

   modport slave (
      input  new_data, signed_mode, tag_in, a_in, b_in, release_data,
      output ack_data, valid_output, tag_out, result
   );
`endif
endinterface

// File: rtl/karatsuba_mul_tracker.sv
// Valid-bit tracker for an elastic pipeline: per-stage valids, the
// bubble-collapsing enable chain, and per-stage data load strobes.
module karatsuba_mul_tracker #(
   parameter int unsigned STAGES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              new_data,
   input  logic              release_data,
   output logic              ack_c,
   output logic              valid_output,
   output logic [STAGES-1:0] load_c
);

   if (STAGES < 2) begin : g_bad_stages
      $error("karatsuba_mul_tracker: STAGES must be >= 2");
   end

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] en_c;

   // Enable chain from the head back: a stage may load when empty or when
   // the stage after it is moving. Data strobes only fire for real entries.
   always_comb begin
      logic en;
      en     = release_data;
      en_c   = '0;
      load_c = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         en      = ~vld_q[k] | en;
         en_c[k] = en;
      end
      load_c[0] = en_c[0] & new_data;
      for (int k = 1; k < STAGES; k++) begin
         load_c[k] = en_c[k] & vld_q[k-1];
      end
      ack_c = new_data & en_c[0] & rst_n;
   end

   // Valid flags advance wherever the enable allows, holding otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else begin
         if (en_c[0]) begin
            vld_q[0] <= new_data;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (en_c[k]) begin
               vld_q[k] <= vld_q[k-1];
            end
         end
      end
   end

   assign valid_output = vld_q[STAGES-1];

endmodule

// File: rtl/karatsuba_mul.sv
// Four-stage elastic Karatsuba multiplier, WIDTH x WIDTH -> 2*WIDTH,
// signed or unsigned per operation, with a pass-through tag.
// Build option: KARATSUBA_MUL_ACC_EN folds a running accumulator into stage 4.
module karatsuba_mul
   import karatsuba_mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) (
   input logic           clk,
   input logic           rst_n,
   karatsuba_mul_if.slave bus
);

   localparam int unsigned HALF_W = half_w(WIDTH);
   localparam int unsigned MID_W  = mid_w(WIDTH);
   localparam int unsigned SUM_W  = sum_w(WIDTH);
   localparam int unsigned RES_W  = res_w(WIDTH);

   if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("karatsuba_mul: WIDTH must be even and >= 4");
   end
   if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
      $error("karatsuba_mul: TAG_W must be in 1..TAG_MAX_W");
   end

   logic [PIPE_STAGES-1:0] load_c;

   karatsuba_mul_tracker #(
      .STAGES (PIPE_STAGES)
   ) u_tracker (
      .clk          (clk),
      .rst_n        (rst_n),
      .new_data     (bus.new_data),
      .release_data (bus.release_data),
      .ack_c        (bus.ack_data),
      .valid_output (bus.valid_output),
      .load_c       (load_c)
   );

   // ---------------- stage 1: magnitudes and sign ----------------
   logic             a_neg_c;
   logic             b_neg_c;
   logic [WIDTH-1:0] a_mag_c;
   logic [WIDTH-1:0] b_mag_c;
   side_t            side_in_c;

   // Strip signs in signed mode; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
   always_comb begin
      a_neg_c              = bus.signed_mode & bus.a_in[WIDTH-1];
      b_neg_c              = bus.signed_mode & bus.b_in[WIDTH-1];
      a_mag_c              = a_neg_c ? WIDTH'(-bus.a_in) : bus.a_in;
      b_mag_c              = b_neg_c ? WIDTH'(-bus.b_in) : bus.b_in;
      side_in_c            = '0;
      side_in_c.sign       = a_neg_c ^ b_neg_c;
      side_in_c.tag        = TAG_MAX_W'(bus.tag_in);
`ifdef KARATSUBA_MUL_ACC_EN
      side_in_c.accumulate = bus.accumulate;
`else
      side_in_c.accumulate = 1'b0;
`endif
   end

   logic [WIDTH-1:0] a1_q;
   logic [WIDTH-1:0] b1_q;
   side_t            s1_q;

   // Stage-1 register: captures an accepted operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q <= '0;
         b1_q <= '0;
         s1_q <= '0;
      end else if (load_c[0]) begin
         a1_q <= a_mag_c;
         b1_q <= b_mag_c;
         s1_q <= side_in_c;
      end
   end

   // ---------------- stage 2: three half-width products ----------------
   logic [HALF_W-1:0] a_hi_c;
   logic [HALF_W-1:0] a_lo_c;
   logic [HALF_W-1:0] b_hi_c;
   logic [HALF_W-1:0] b_lo_c;
   logic [HALF_W:0]   a_sum_c;
   logic [HALF_W:0]   b_sum_c;
   logic [WIDTH-1:0]  z2_c;
   logic [WIDTH-1:0]  z0_c;
   logic [SUM_W-1:0]  zs_c;

   // High, low and cross-sum products replace the four schoolbook partials.
   always_comb begin
      a_hi_c  = a1_q[WIDTH-1:HALF_W];
      a_lo_c  = a1_q[HALF_W-1:0];
      b_hi_c  = b1_q[WIDTH-1:HALF_W];
      b_lo_c  = b1_q[HALF_W-1:0];
      a_sum_c = (HALF_W+1)'(a_hi_c) + (HALF_W+1)'(a_lo_c);
      b_sum_c = (HALF_W+1)'(b_hi_c) + (HALF_W+1)'(b_lo_c);
      z2_c    = WIDTH'(a_hi_c) * WIDTH'(b_hi_c);
      z0_c    = WIDTH'(a_lo_c) * WIDTH'(b_lo_c);
      zs_c    = SUM_W'(a_sum_c) * SUM_W'(b_sum_c);
   end

   logic [WIDTH-1:0] z2_q;
   logic [WIDTH-1:0] z0_q;
   logic [SUM_W-1:0] zs_q;
   side_t            s2_q;

   // Stage-2 register: partial products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z2_q <= '0;
         z0_q <= '0;
         zs_q <= '0;
         s2_q <= '0;
      end else if (load_c[1]) begin
         z2_q <= z2_c;
         z0_q <= z0_c;
         zs_q <= zs_c;
         s2_q <= s1_q;
      end
   end

   // ---------------- stage 3: middle term ----------------
   logic [MID_W-1:0] mid_c;

   // Middle term equals H1*L2 + L1*H2, so it never goes negative.
   always_comb begin
      mid_c = MID_W'(zs_q - SUM_W'(z2_q) - SUM_W'(z0_q));
   end

   logic [RES_W-1:0] zz_q;
   logic [MID_W-1:0] mid_q;
   side_t            s3_q;

   // Stage-3 register: concatenated outer products and the middle term.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zz_q  <= '0;
         mid_q <= '0;
         s3_q  <= '0;
      end else if (load_c[2]) begin
         zz_q  <= {z2_q, z0_q};
         mid_q <= mid_c;
         s3_q  <= s2_q;
      end
   end

   // ---------------- stage 4: recombine and apply sign ----------------
   logic [RES_W-1:0] p_c;
   logic [RES_W-1:0] p_signed_c;
   logic [RES_W-1:0] value_c;

`ifdef KARATSUBA_MUL_ACC_EN
   logic [RES_W-1:0] acc_q;
`endif

   // Recombine the magnitude, restore the sign, optionally add the accumulator.
   always_comb begin
      p_c        = zz_q + (RES_W'(mid_q) << HALF_W);
      p_signed_c = s3_q.sign ? RES_W'(-p_c) : p_c;
`ifdef KARATSUBA_MUL_ACC_EN
      value_c    = p_signed_c + (s3_q.accumulate ? acc_q : '0);
`else
      value_c    = p_signed_c;
`endif
   end

   // Output register: result and tag hold while the head is not released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result  <= '0;
         bus.tag_out <= '0;
      end else if (load_c[3]) begin
         bus.result  <= value_c;
         bus.tag_out <= s3_q.tag[TAG_W-1:0];
      end
   end

`ifdef KARATSUBA_MUL_ACC_EN
   // Accumulator follows stage-4 loads so dependent ops chain without stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (load_c[3]) begin
         acc_q <= value_c;
      end
   end
`endif

   // Upper tag bits and, in the plain build, the accumulate flag are dead here.
   logic unused_side;
   assign unused_side = ^{s3_q.tag, s3_q.accumulate};

endmodule

// File: tb/tb_karatsuba_mul.sv
// Directed bench for karatsuba_mul at WIDTH=8, TAG_W=4.
// With KARATSUBA_MUL_ACC_EN defined it also exercises the accumulator chain.
module tb_karatsuba_mul;

   logic clk;
   logic rst_n;

   karatsuba_mul_if #(.WIDTH(8), .TAG_W(4)) bus ();

   karatsuba_mul #(
      .WIDTH (8),
      .TAG_W (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  tag;
      logic [15:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec;
   int   n_err;
   logic obs_valid;
   logic last_ack;
   logic acc_drv;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // One clock cycle: sample outputs, drive inputs, check a released head,
   // queue the expected result of an accepted op.
   task automatic cycle(input logic nd, input logic sm, input logic [3:0] tg,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic rel, input logic [15:0] want);
      exp_t e;
      @(negedge clk);
      obs_valid            = bus.valid_output;
      bus.new_data         = nd;
      bus.signed_mode      = sm;
      bus.tag_in           = tg;
      bus.a_in             = a;
      bus.b_in             = b;
      bus.release_data     = rel;
`ifdef KARATSUBA_MUL_ACC_EN
      bus.accumulate       = acc_drv;
`endif
      #1;
      last_ack = bus.ack_data;
      if (obs_valid && rel) begin
         if (exp_q.size() == 0) begin
            chk("extra_result", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", 32'(bus.result), 32'(e.res));
            chk("tag_out", 32'(bus.tag_out), 32'(e.tag));
         end
      end
      if (last_ack) begin
         e.tag = tg;
         e.res = want;
         exp_q.push_back(e);
      end
   endtask

   // Idle cycles with release high; reports when valid results appeared.
   task automatic drain(input int max_cyc, output int nv, output int first, output int last);
      nv    = 0;
      first = 0;
      last  = 0;
      for (int i = 1; i <= max_cyc; i++) begin
         cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1, 16'h0000);
         if (obs_valid) begin
            nv++;
            if (first == 0) first = i;
            last = i;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, first, last, acks;
      n_vec            = 0;
      n_err            = 0;
      acc_drv          = 1'b0;
      rst_n            = 1'b0;
      bus.new_data     = 1'b1;
      bus.signed_mode  = 1'b0;
      bus.tag_in       = 4'h0;
      bus.a_in         = 8'h00;
      bus.b_in         = 8'h00;
      bus.release_data = 1'b1;
`ifdef KARATSUBA_MUL_ACC_EN
      bus.accumulate   = 1'b0;
`endif
      // Reset state, with an op offered to show ack stays low.
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(bus.valid_output), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_tag", 32'(bus.tag_out), 32'd0);
      chk("rst_ack", 32'(bus.ack_data), 32'd0);
      bus.new_data = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Latency: one unsigned op, release held high.
      cycle(1'b1, 1'b0, 4'h3, 8'hFF, 8'hFF, 1'b1, 16'hFE01);
      chk("lat_ack", 32'(last_ack), 32'd1);
      drain(8, nv, first, last);
      chk("lat_cycles", 32'(first), 32'd4);
      chk("lat_count", 32'(nv), 32'd1);

      // Back-to-back mixed signed/unsigned ops.
      cycle(1'b1, 1'b1, 4'h1, 8'h80, 8'h80, 1'b1, 16'h4000);
      chk("b2b_ack0", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b1, 4'h2, 8'hFD, 8'h05, 1'b1, 16'hFFF1);
      chk("b2b_ack1", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b0, 4'h4, 8'h80, 8'h02, 1'b1, 16'h0100);
      chk("b2b_ack2", 32'(last_ack), 32'd1);
      drain(8, nv, first, last);
      chk("b2b_count", 32'(nv), 32'd3);
      chk("b2b_first", 32'(first), 32'd2);
      chk("b2b_span", 32'(last - first + 1), 32'd3);

      // Backpressure: four ops fill the pipe, fifth is refused while stalled.
      cycle(1'b1, 1'b0, 4'h5, 8'h12, 8'h34, 1'b0, 16'h03A8);
      chk("bp_ack0", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b1, 4'h6, 8'h7F, 8'h7F, 1'b0, 16'h3F01);
      chk("bp_ack1", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b1, 4'h7, 8'h80, 8'h7F, 1'b0, 16'hC080);
      chk("bp_ack2", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b0, 4'h8, 8'h00, 8'hAB, 1'b0, 16'h0000);
      chk("bp_ack3", 32'(last_ack), 32'd1);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 4'h9, 8'hFF, 8'h01, 1'b0, 16'hFFFF);
         chk("bp_full_ack", 32'(last_ack), 32'd0);
         chk("bp_hold_valid", 32'(obs_valid), 32'd1);
         chk("bp_hold_result", 32'(bus.result), 32'h03A8);
         chk("bp_hold_tag", 32'(bus.tag_out), 32'h5);
      end
      cycle(1'b1, 1'b1, 4'h9, 8'hFF, 8'h01, 1'b1, 16'hFFFF);
      chk("bp_release_ack", 32'(last_ack), 32'd1);
      cycle(1'b1, 1'b0, 4'hA, 8'h0F, 8'h10, 1'b1, 16'h00F0);
      chk("bp_next_ack", 32'(last_ack), 32'd1);
      drain(10, nv, first, last);
      chk("bp_drain_count", 32'(nv), 32'd4);
      chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

      // Bubbles collapse while stalled: four sparse ops fill all stages.
      acks = 0;
      cycle(1'b1, 1'b0, 4'h1, 8'h03, 8'h03, 1'b0, 16'h0009);
      acks += int'(last_ack);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 16'h0000);
      cycle(1'b1, 1'b1, 4'h2, 8'hFE, 8'hFE, 1'b0, 16'h0004);
      acks += int'(last_ack);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 16'h0000);
      cycle(1'b1, 1'b0, 4'h3, 8'hAA, 8'h55, 1'b0, 16'h3872);
      acks += int'(last_ack);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 16'h0000);
      cycle(1'b1, 1'b1, 4'h4, 8'h40, 8'hC0, 1'b0, 16'hF000);
      acks += int'(last_ack);
      cycle(1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 16'h0000);
      chk("bub_acks", 32'(acks), 32'd4);
      cycle(1'b1, 1'b0, 4'h5, 8'h02, 8'h02, 1'b0, 16'h0004);
      chk("bub_full_ack", 32'(last_ack), 32'd0);
      cycle(1'b1, 1'b0, 4'h5, 8'h02, 8'h02, 1'b1, 16'h0004);
      chk("bub_release_ack", 32'(last_ack), 32'd1);
      drain(10, nv, first, last);
      chk("bub_drain_count", 32'(nv), 32'd4);
      chk("bub_queue_empty", 32'(exp_q.size()), 32'd0);

      // Reset with three ops in flight: everything discarded at once.
      cycle(1'b1, 1'b0, 4'h1, 8'h11, 8'h11, 1'b1, 16'h0121);
      cycle(1'b1, 1'b0, 4'h2, 8'h22, 8'h02, 1'b1, 16'h0044);
      cycle(1'b1, 1'b1, 4'h3, 8'hF0, 8'h02, 1'b1, 16'hFFE0);
      chk("mid_rst_acked", 32'(exp_q.size()), 32'd3);
      @(negedge clk);
      rst_n            = 1'b0;
      bus.new_data     = 1'b1;
      bus.release_data = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(bus.valid_output), 32'd0);
      chk("mid_rst_result", 32'(bus.result), 32'd0);
      chk("mid_rst_tag", 32'(bus.tag_out), 32'd0);
      chk("mid_rst_ack", 32'(bus.ack_data), 32'd0);
      exp_q.delete();
      bus.new_data = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      cycle(1'b1, 1'b1, 4'hF, 8'h05, 8'hF9, 1'b1, 16'hFFDD);
      chk("post_rst_ack", 32'(last_ack), 32'd1);
      drain(8, nv, first, last);
      chk("post_rst_count", 32'(nv), 32'd1);
      chk("post_rst_lat", 32'(first), 32'd4);

`ifdef KARATSUBA_MUL_ACC_EN
      // Accumulator chain issued back-to-back.
      acc_drv = 1'b0;
      cycle(1'b1, 1'b1, 4'h1, 8'h02, 8'h03, 1'b1, 16'h0006);
      acc_drv = 1'b1;
      cycle(1'b1, 1'b1, 4'h2, 8'h04, 8'h05, 1'b1, 16'h001A);
      cycle(1'b1, 1'b1, 4'h3, 8'hFF, 8'h07, 1'b1, 16'h0013);
      acc_drv = 1'b0;
      cycle(1'b1, 1'b1, 4'h4, 8'h01, 8'h01, 1'b1, 16'h0001);
      drain(8, nv, first, last);
      chk("acc_count", 32'(nv), 32'd4);
      chk("acc_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
